// File: rtl/cpu_bus_pkg.sv
// cpu_bus_pkg: shared types and constants for the RAM bus arbiter slice
package cpu_bus_pkg;
    localparam int BUS_ADDR_W = 16;
    localparam int BUS_DATA_W = 64;
    localparam logic PORT_IF = 1'b0;
    localparam logic PORT_D = 1'b1;
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} arb_state_t;
endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: combinational two-way round-robin picker
module rr_arbiter2
    import cpu_bus_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       grant,
    output logic       valid
);
    assign valid = |req;
    assign grant = &req ? ~last_grant : req[PORT_D];
endmodule

// File: rtl/ram_bus_arbiter.sv
// ram_bus_arbiter: shares the single-port data RAM between fetch and load/store ports
module ram_bus_arbiter
    import cpu_bus_pkg::*;
#(
    parameter int ADDR_W  = BUS_ADDR_W,
    parameter int DATA_W  = BUS_DATA_W,
    parameter int RAM_LAT = 1
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [31:0]       if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              ram_cs,
    output logic              ram_rd,
    output logic              ram_wr,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              busy
);
    localparam int CW = $clog2(RAM_LAT + 1);

    generate
        if (RAM_LAT < 1) begin : g_lat_chk
            $error("RAM_LAT must be at least 1");
        end
    endgenerate

    arb_state_t    state;
    logic          last_grant;
    logic          port;
    logic [CW-1:0] cnt;
    logic          grant;
    logic          gvalid;
    logic          store;

    rr_arbiter2 u_rr (
        .req       ({d_req, if_req}),
        .last_grant(last_grant),
        .grant     (grant),
        .valid     (gvalid)
    );

    assign store = (grant == PORT_D) && d_we;

    // The address/data registers double as the latched request, so inputs are ignored once granted
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state      <= IDLE;
            last_grant <= PORT_D;
            port       <= PORT_IF;
            cnt        <= '0;
            ram_cs     <= 1'b0;
            ram_rd     <= 1'b0;
            ram_wr     <= 1'b0;
            ram_addr   <= '0;
            ram_wdata  <= '0;
            if_ack     <= 1'b0;
            d_ack      <= 1'b0;
            if_rdata   <= '0;
            d_rdata    <= '0;
            busy       <= 1'b0;
        end else begin
            if_ack <= 1'b0;
            d_ack  <= 1'b0;
            case (state)
                IDLE: if (gvalid) begin
                    state      <= ACCESS;
                    busy       <= 1'b1;
                    port       <= grant;
                    last_grant <= grant;
                    cnt        <= '0;
                    ram_cs     <= 1'b1;
                    ram_rd     <= ~store;
                    ram_wr     <= store;
                    ram_addr   <= (grant == PORT_D) ? d_addr : if_addr;
                    ram_wdata  <= (grant == PORT_D) ? d_wdata : '0;
                end
                ACCESS: if (cnt == CW'(RAM_LAT - 1)) begin
                    state  <= DONE;
                    ram_cs <= 1'b0;
                    ram_rd <= 1'b0;
                    ram_wr <= 1'b0;
                    if_ack <= (port == PORT_IF);
                    d_ack  <= (port == PORT_D);
                    if (port == PORT_IF) if_rdata <= ram_rdata[31:0];
                    else if (!ram_wr) d_rdata <= ram_rdata;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule
